// File: rtl/ps2_kbd_matrix_if.sv
// PS/2 keyboard to C64 matrix bridge: bundled PS/2 lines, CIA1 matrix lines
// and scan-code observation outputs.
interface ps2_kbd_matrix_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyboard_ROW;
    logic [7:0] keyboard_COL;
    logic       scan_strobe;
    logic [7:0] scan_code;
    logic       restore;

    // Driver side (keyboard + CIA1 port A), observes results
    modport master (
        output ps2_clk, ps2_data, keyboard_ROW,
        input  keyboard_COL, scan_strobe, scan_code, restore
    );

    // Converter side
    modport slave (
        input  ps2_clk, ps2_data, keyboard_ROW,
        output keyboard_COL, scan_strobe, scan_code, restore
    );
endinterface

// File: rtl/ps2_kbd_matrix.sv
// PS/2 (scancode set 2) keyboard to C64 8x8 key matrix converter.
// Optional RESTORE key on E0 7D (PageUp) enabled by macro PS2_RESTORE_KEY_EN.
module ps2_kbd_matrix #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 16384
) (
    input  logic             clk,
    input  logic             reset,
    ps2_kbd_matrix_if.slave  bus
);
    localparam int unsigned FW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0]  r_filt_cnt;
    logic           r_filt_lvl;
    logic           r_fall;
    state_t         r_state;
    logic [2:0]     r_bitcnt;
    logic [7:0]     r_shift;
    logic           r_par;
    logic [TOW-1:0] r_to_cnt;
    logic           r_scan_strobe;
    logic [7:0]     r_scan_code;
    logic           r_brk, r_ext;
    logic [63:0]    r_key;
    logic [6:0]     w_map;
    logic [7:0]     w_col;

    // Two-flop synchronisers for both PS/2 lines (idle level is high)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;  r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data; r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: level follows only after FILTER_LEN consecutive new samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_cnt <= '0;
            r_filt_lvl <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 == r_filt_lvl) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_cnt <= '0;
                r_filt_lvl <= r_clk_s2;
                r_fall     <= ~r_clk_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    // Frame receiver: start, 8 data LSB first, odd parity, stop; with timeout abort
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_to_cnt      <= '0;
            r_scan_strobe <= 1'b0;
            r_scan_code   <= '0;
        end else begin
            r_scan_strobe <= 1'b0;
            if (r_fall || r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TOW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + TOW'(1);
            end

            if (r_state != S_IDLE && !r_fall && r_to_cnt == TOW'(TIMEOUT)) begin
                r_state <= S_IDLE;
            end else if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    default: begin
                        if (r_dat_s2 && (^{r_shift, r_par})) begin
                            r_scan_strobe <= 1'b1;
                            r_scan_code   <= r_shift;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Scancode to matrix position lookup: {hit, row[2:0], col[2:0]}
    always_comb begin
        w_map = '0;
        case ({r_ext, r_scan_code})
            9'h01C: w_map = {1'b1, 3'd1, 3'd2};  // A
            9'h032: w_map = {1'b1, 3'd3, 3'd4};  // B
            9'h021: w_map = {1'b1, 3'd2, 3'd4};  // C
            9'h023: w_map = {1'b1, 3'd2, 3'd2};  // D
            9'h024: w_map = {1'b1, 3'd1, 3'd6};  // E
            9'h02B: w_map = {1'b1, 3'd2, 3'd5};  // F
            9'h034: w_map = {1'b1, 3'd3, 3'd2};  // G
            9'h033: w_map = {1'b1, 3'd3, 3'd5};  // H
            9'h043: w_map = {1'b1, 3'd4, 3'd1};  // I
            9'h03B: w_map = {1'b1, 3'd4, 3'd2};  // J
            9'h042: w_map = {1'b1, 3'd4, 3'd5};  // K
            9'h04B: w_map = {1'b1, 3'd5, 3'd2};  // L
            9'h03A: w_map = {1'b1, 3'd4, 3'd4};  // M
            9'h031: w_map = {1'b1, 3'd4, 3'd7};  // N
            9'h044: w_map = {1'b1, 3'd4, 3'd6};  // O
            9'h04D: w_map = {1'b1, 3'd5, 3'd1};  // P
            9'h015: w_map = {1'b1, 3'd7, 3'd6};  // Q
            9'h02D: w_map = {1'b1, 3'd2, 3'd1};  // R
            9'h01B: w_map = {1'b1, 3'd1, 3'd5};  // S
            9'h02C: w_map = {1'b1, 3'd2, 3'd6};  // T
            9'h03C: w_map = {1'b1, 3'd3, 3'd6};  // U
            9'h02A: w_map = {1'b1, 3'd3, 3'd7};  // V
            9'h01D: w_map = {1'b1, 3'd1, 3'd1};  // W
            9'h022: w_map = {1'b1, 3'd2, 3'd7};  // X
            9'h035: w_map = {1'b1, 3'd3, 3'd1};  // Y
            9'h01A: w_map = {1'b1, 3'd1, 3'd4};  // Z
            9'h016: w_map = {1'b1, 3'd7, 3'd0};  // 1
            9'h01E: w_map = {1'b1, 3'd7, 3'd3};  // 2
            9'h026: w_map = {1'b1, 3'd1, 3'd0};  // 3
            9'h025: w_map = {1'b1, 3'd1, 3'd3};  // 4
            9'h02E: w_map = {1'b1, 3'd2, 3'd0};  // 5
            9'h036: w_map = {1'b1, 3'd2, 3'd3};  // 6
            9'h03D: w_map = {1'b1, 3'd3, 3'd0};  // 7
            9'h03E: w_map = {1'b1, 3'd3, 3'd3};  // 8
            9'h046: w_map = {1'b1, 3'd4, 3'd0};  // 9
            9'h045: w_map = {1'b1, 3'd4, 3'd3};  // 0
            9'h05A: w_map = {1'b1, 3'd0, 3'd1};  // Return
            9'h029: w_map = {1'b1, 3'd7, 3'd4};  // Space
            9'h012: w_map = {1'b1, 3'd1, 3'd7};  // LShift
            9'h059: w_map = {1'b1, 3'd6, 3'd4};  // RShift
            9'h076: w_map = {1'b1, 3'd7, 3'd7};  // Esc -> RUN/STOP
            9'h00D: w_map = {1'b1, 3'd7, 3'd2};  // Tab -> CTRL
            9'h014: w_map = {1'b1, 3'd7, 3'd5};  // LCtrl -> C=
            9'h172: w_map = {1'b1, 3'd0, 3'd7};  // Down
            9'h174: w_map = {1'b1, 3'd0, 3'd2};  // Right
            default: w_map = '0;
        endcase
    end

`ifdef PS2_RESTORE_KEY_EN
    logic r_restore;

    // RESTORE level tracks make/break of E0 7D
    always_ff @(posedge clk) begin
        if (reset) begin
            r_restore <= 1'b0;
        end else if (r_scan_strobe && r_ext && r_scan_code == 8'h7D) begin
            r_restore <= ~r_brk;
        end
    end
    assign bus.restore = r_restore;
`else
    assign bus.restore = 1'b0;
`endif

    // Prefix tracking and key state update on each valid byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
            r_key <= '0;
        end else if (r_scan_strobe) begin
            case (r_scan_code)
                8'hF0: r_brk <= 1'b1;
                8'hE0: r_ext <= 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                default: begin
                    if (w_map[6]) r_key[w_map[5:0]] <= ~r_brk;
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            endcase
        end
    end

    // Column returns: low where any selected row has that key pressed
    always_comb begin
        w_col = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!bus.keyboard_ROW[r] && r_key[r*8 + c]) w_col[c] = 1'b0;
            end
        end
    end

    assign bus.keyboard_COL = w_col;
    assign bus.scan_strobe  = r_scan_strobe;
    assign bus.scan_code    = r_scan_code;
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Bench for ps2_kbd_matrix: table of scancode sequences with expected matrix
// columns, strobe scoreboard, and hand sequences for corrupt/partial frames.
module tb_ps2_kbd_matrix;
    localparam int TIMEOUT = 16384;
    localparam int HALF    = 20;
    localparam int GAP     = 40;
`ifdef PS2_RESTORE_KEY_EN
    localparam bit RESTORE_EN = 1'b1;
`else
    localparam bit RESTORE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    ps2_kbd_matrix_if bus ();

    ps2_kbd_matrix #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_code = 8'h00;

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] codes;
        logic [7:0]      row;
        logic [7:0]      col;
        logic            rst;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input int n, input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3,
                                input logic [7:0] row, input logic [7:0] col, input logic rst);
        vec_t v;
        v.n = 3'(n);
        v.codes[0] = c0; v.codes[1] = c1; v.codes[2] = c2; v.codes[3] = c3;
        v.row = row; v.col = col; v.rst = rst;
        return v;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected byte
    always @(negedge clk) begin
        if (!reset && bus.scan_strobe) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: got unexpected byte %h expected none", bus.scan_code);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (bus.scan_code !== e) begin
                    errors++;
                    $display("FAIL strobe: got %h expected %h", bus.scan_code, e);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        bus.ps2_data = b;
        if (glitch) begin
            wait_clk(HALF / 2);
            bus.ps2_clk = 1'b0;
            wait_clk(3);
            bus.ps2_clk = 1'b1;
            wait_clk(HALF - HALF / 2 - 3);
        end else begin
            wait_clk(HALF);
        end
        bus.ps2_clk = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        if (!bad_par && !bad_stop) begin
            sb_q.push_back(b);
            last_code = b;
        end
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit((~^b) ^ bad_par, glitch);
        send_bit(~bad_stop, glitch);
        bus.ps2_data = 1'b1;
        wait_clk(GAP);
    endtask

    task automatic check_col(input string name, input logic [7:0] row, input logic [7:0] exp);
        bus.keyboard_ROW = row;
        wait_clk(2);
        @(negedge clk);
        check8(name, bus.keyboard_COL, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFB, 1'b0);
        vecs[1]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0);
        vecs[2]  = mk(2, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'hFD, 8'hFF, 1'b0);
        vecs[3]  = mk(2, 8'h12, 8'h59, 8'h00, 8'h00, 8'hBD, 8'h6F, 1'b0);
        vecs[4]  = mk(4, 8'hF0, 8'h12, 8'hF0, 8'h59, 8'hBD, 8'hFF, 1'b0);
        vecs[5]  = mk(2, 8'hE0, 8'h74, 8'h00, 8'h00, 8'hFE, 8'hFB, 1'b0);
        vecs[6]  = mk(3, 8'hE0, 8'hF0, 8'h74, 8'h00, 8'hFE, 8'hFF, 1'b0);
        vecs[7]  = mk(2, 8'hE0, 8'h72, 8'h00, 8'h00, 8'hFE, 8'h7F, 1'b0);
        vecs[8]  = mk(3, 8'hF0, 8'hE0, 8'h72, 8'h00, 8'hFE, 8'hFF, 1'b0);
        vecs[9]  = mk(2, 8'h76, 8'h29, 8'h00, 8'h00, 8'h7F, 8'h6F, 1'b0);
        vecs[10] = mk(1, 8'h76, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h6F, 1'b0);
        vecs[11] = mk(4, 8'hF0, 8'h76, 8'hF0, 8'h29, 8'h7F, 8'hFF, 1'b0);
        vecs[12] = mk(3, 8'hE0, 8'h75, 8'h1C, 8'h00, 8'hFD, 8'hFB, 1'b0);
        vecs[13] = mk(4, 8'hAA, 8'hF0, 8'hFA, 8'h1C, 8'hFD, 8'hFF, 1'b0);
        vecs[14] = mk(3, 8'hE0, 8'h7D, 8'h16, 8'h00, 8'h7F, 8'hFE, RESTORE_EN);
        vecs[15] = mk(4, 8'hE0, 8'hF0, 8'h7D, 8'h00, 8'h7F, 8'hFE, 1'b0);
        vecs[16] = mk(4, 8'hF0, 8'h16, 8'h1C, 8'h5A, 8'hFC, 8'hF9, 1'b0);
        vecs[17] = mk(4, 8'hF0, 8'h1C, 8'hF0, 8'h5A, 8'hFC, 8'hFF, 1'b0);

        reset = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.keyboard_ROW = 8'h00;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        @(negedge clk);
        check8("reset_col", bus.keyboard_COL, 8'hFF);
        check8("reset_code", bus.scan_code, 8'h00);
        check8("reset_strobe", 8'(bus.scan_strobe), 8'h00);
        check8("reset_restore", 8'(bus.restore), 8'h00);

        for (int i = 0; i < 18; i++) begin
            for (int k = 0; k < int'(vecs[i].n); k++) send_frame(vecs[i].codes[k], 1'b0, 1'b0, 1'b0);
            check_col($sformatf("vec%0d_col", i), vecs[i].row, vecs[i].col);
            check8($sformatf("vec%0d_restore", i), 8'(bus.restore), 8'(vecs[i].rst));
        end

        // Corrupt parity and corrupt stop: discarded, code holds
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check8("badpar_code", bus.scan_code, last_code);
        check_col("badpar_col", 8'hFD, 8'hFF);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check8("badstop_code", bus.scan_code, last_code);
        check_col("badstop_col", 8'hFD, 8'hFF);

        // Partial frame abandoned by timeout, then a full frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        bus.ps2_data = 1'b1;
        wait_clk(TIMEOUT + 10);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check8("timeout_code", bus.scan_code, 8'h5A);
        check_col("timeout_col", 8'hFE, 8'hFD);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_col("timeout_rel", 8'hFE, 8'hFF);

        // Short ps2_clk glitches while idle and within a frame
        for (int i = 0; i < 5; i++) begin
            bus.ps2_clk = 1'b0;
            wait_clk(3);
            bus.ps2_clk = 1'b1;
            wait_clk(10);
        end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        check8("glitch_code", bus.scan_code, 8'h1C);
        check_col("glitch_col", 8'hFD, 8'hFB);

        // Reset in the middle of a frame with a key held
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        bus.ps2_data = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last_code = 8'h00;
        check_col("midrst_col", 8'h00, 8'hFF);
        check8("midrst_code", bus.scan_code, 8'h00);
        check8("midrst_strobe", 8'(bus.scan_strobe), 8'h00);
        check8("midrst_restore", 8'(bus.restore), 8'h00);
        wait_clk(GAP);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check8("postrst_code", bus.scan_code, 8'h29);
        check_col("postrst_col", 8'h7F, 8'hEF);

        wait_clk(GAP);
        check8("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
